reg_bank_wid: RTL and testbench
===============================

Name: reg_bank_wid

Overview:
- Parametrised bank of DEPTH general-purpose registers, each WIDTH bits wide.
- Each register supports bus write, step increment, step decrement and a selectable wrap or saturate mode, with a sticky per-register overflow flag.
- Successor to the single write/increment register in the pointcloud datapath. It holds the point index, address and loop counters for the controller.
- One write port, one increment/decrement port and one read port per cycle, each with an independent select.

Parameters:
- WIDTH, 8, bit width of each register and of the bus.
- DEPTH, 4, number of registers (must be ≥2).
- STEP, 1, amount added by INC or subtracted by DEC. Must satisfy 1 ≤ STEP < 2^WIDTH.
- SATURATE, 0, 0 = modular wrap, 1 = clamp at 0 and at 2^WIDTH-1.
- SELW, $clog2(DEPTH), select width. Derived; do not override.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  synchronous active-high reset.
- WEN  input  1  write enable for register WSel.
- WSel  input  SELW  write target.
- BusOut  input  WIDTH  write data.
- INC  input  1  increment register ISel by STEP.
- DEC  input  1  decrement register ISel by STEP.
- ISel  input  SELW  increment/decrement target.
- RSel  input  SELW  read select.
- ClrOvf  input  1  clear all overflow flags.
- dout  output  WIDTH  contents of register RSel (combinational read of state).
- ovf  output  DEPTH  sticky overflow flag per register. Bit i belongs to register i.

Behaviour:
- Reset:
  - Rst high at a rising edge sets all registers and all ovf bits to 0.
  - After that edge, dout = 0.
  - Rst overrides every other input in that cycle.
  - Rst asserted mid-operation discards any pending write or increment in the same cycle.
- Latency:
  - A write or step takes effect at the rising edge.
  - The new value is visible on dout in the following cycle when RSel points to it.
  - dout follows RSel combinationally, with no extra register stage.
- Write: WEN=1 loads BusOut into reg[WSel] and clears ovf[WSel], unless a new overflow sets it in the same cycle (not possible on a write path).
- Step, applied to reg[ISel]:
  - INC=1, DEC=0: new = old + STEP.
  - INC=0, DEC=1: new = old - STEP.
  - INC=1, DEC=1: no change, and no ovf update.
- Arithmetic:
  - Computed in WIDTH+1 bits.
  - Carry-out on INC or borrow on DEC marks an overflow event.
- Wrap mode (SATURATE=0): result is truncated to WIDTH bits and an overflow event sets ovf[ISel].
- Saturate mode (SATURATE=1): on an overflow event the result clamps to 2^WIDTH-1 (INC) or 0 (DEC) and ovf[ISel] sets.
- Step at the boundary:
  - A step from a value already at the clamp bound is itself an overflow event.
  - Example: 255 + 1 sets ovf and stays at 255.
- Collision: WEN with WSel == ISel means the write wins. The step is dropped, ovf[ISel] is not set, and ovf is cleared per the write rule.
- No collision: WEN and a step on different registers in one cycle are both applied.
- ClrOvf:
  - Clears all ovf bits at the edge.
  - A new overflow event in the same cycle wins for its own bit, and that bit reads 1.
  - Register contents are unaffected.
- ovf is sticky: once set it holds until ClrOvf, a write to that register, or Rst.
- Out-of-range select (DEPTH not a power of two):
  - A WSel or ISel ≥ DEPTH makes that operation a no-op.
  - RSel ≥ DEPTH makes dout read 0.
- Undriven inputs (X) are not required to be tolerated. The bench drives all inputs from time 0.

Test Plan:
- WIDTH=8, DEPTH=4, STEP=1, SATURATE=0:
  - Rst for 2 cycles -> dout=0, ovf=4'b0000.
  - Then WEN=1, WSel=2, BusOut=8'hAA, RSel=2 -> dout=8'hAA in the next cycle. Registers 0, 1 and 3 read 0.
- Wrap: write reg1=8'hFE, then 3 cycles INC with ISel=1 -> dout sequence 8'hFF, 8'h00, 8'h01. ovf[1] sets on the FF->00 edge and stays set. ClrOvf for 1 cycle -> ovf=0.
- Saturate: rebuild with SATURATE=1, STEP=4. Write reg0=8'h03, then DEC -> reg0=8'h00 with ovf[0]=1. Write reg3=8'hFD, then INC -> 8'hFF with ovf[3]=1. A further INC -> 8'hFF, ovf[3] still 1.
- Collision:
  - Same register: WEN=1, WSel=1, BusOut=8'h10 with INC=1, ISel=1 in one cycle -> reg1=8'h10, and ovf[1] is cleared if it was set.
  - Different registers: WSel=0, ISel=1 in the same cycle -> reg0=BusOut and reg1 incremented.
  - Both directions: INC=DEC=1 -> target register unchanged.
- Reset mid-operation: with reg2=8'h55 and ovf=4'b0110, assert Rst together with WEN=1 and INC=1 -> all registers 0, ovf=0. No write is observed.
- Random: 200 cycles of $random on WEN, INC, DEC, selects, BusOut and ClrOvf. Compare every cycle against a behavioural model of the bank, checking dout and ovf.

Source files
------------

// File: rtl/reg_bank_wid.sv
// reg_bank_wid: bank of DEPTH registers with bus write, step inc/dec, wrap or saturate, sticky overflow
// Ports:
//   Clk, Rst        rising-edge clock, synchronous active-high reset
//   WEN/WSel/BusOut write port: loads BusOut into reg[WSel], clears ovf[WSel]
//   INC/DEC/ISel    step port: reg[ISel] +/- STEP (both high = no-op)
//   RSel/dout       combinational read port, out-of-range select reads 0
//   ClrOvf          clears all sticky overflow flags
//   ovf             per-register sticky overflow flags
module reg_bank_wid #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int STEP     = 1,
    parameter int SATURATE = 0,
    parameter int SELW     = $clog2(DEPTH)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             WEN,
    input  logic [SELW-1:0]  WSel,
    input  logic [WIDTH-1:0] BusOut,
    input  logic             INC,
    input  logic             DEC,
    input  logic [SELW-1:0]  ISel,
    input  logic [SELW-1:0]  RSel,
    input  logic             ClrOvf,
    output logic [WIDTH-1:0] dout,
    output logic [DEPTH-1:0] ovf
);
    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);
    localparam logic [SELW:0]  DEPTH_X = (SELW+1)'(DEPTH);

    logic [WIDTH-1:0] regs [DEPTH];
    logic             wr_ok, step_ok, step_ovf;
    logic [WIDTH:0]   step_raw;
    logic [WIDTH-1:0] step_val;

    assign wr_ok = WEN && ({1'b0, WSel} < DEPTH_X);
    // A write to the same register wins over the step; INC and DEC together cancel.
    assign step_ok = (INC ^ DEC) && ({1'b0, ISel} < DEPTH_X) && !(wr_ok && WSel == ISel);
    // Bit WIDTH of the extended result is the carry (INC) or borrow (DEC).
    assign step_raw = INC ? {1'b0, regs[ISel]} + STEP_X : {1'b0, regs[ISel]} - STEP_X;
    assign step_ovf = step_raw[WIDTH];
    assign step_val = (step_ovf && SATURATE != 0) ? (INC ? '1 : '0) : step_raw[WIDTH-1:0];
    assign dout = ({1'b0, RSel} < DEPTH_X) ? regs[RSel] : '0;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            ovf <= '0;
        end else begin
            if (ClrOvf) ovf <= '0;
            if (step_ok) begin
                regs[ISel] <= step_val;
                if (step_ovf) ovf[ISel] <= 1'b1;
            end
            if (wr_ok) begin
                regs[WSel] <= BusOut;
                ovf[WSel]  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_reg_bank_wid.sv
// tb_reg_bank_wid: scoreboard bench driving a wrap bank and a saturate bank with shared stimulus
module tb_reg_bank_wid;
    logic       Clk = 0, Rst = 1, WEN = 0, INC = 0, DEC = 0, ClrOvf = 0;
    logic [1:0] WSel = 0, ISel = 0, RSel = 0;
    logic [7:0] BusOut = 0;
    logic [7:0] dout_w, dout_s;
    logic [3:0] ovf_w, ovf_s;

    reg_bank_wid #(.WIDTH(8), .DEPTH(4), .STEP(1), .SATURATE(0)) dut_w (
        .Clk(Clk), .Rst(Rst), .WEN(WEN), .WSel(WSel), .BusOut(BusOut), .INC(INC), .DEC(DEC),
        .ISel(ISel), .RSel(RSel), .ClrOvf(ClrOvf), .dout(dout_w), .ovf(ovf_w));
    reg_bank_wid #(.WIDTH(8), .DEPTH(4), .STEP(4), .SATURATE(1)) dut_s (
        .Clk(Clk), .Rst(Rst), .WEN(WEN), .WSel(WSel), .BusOut(BusOut), .INC(INC), .DEC(DEC),
        .ISel(ISel), .RSel(RSel), .ClrOvf(ClrOvf), .dout(dout_s), .ovf(ovf_s));

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] dw, ds, cd;
        logic [3:0] ow, os, co;
        int         csel;
        string      name;
    } exp_t;

    exp_t     q[$];
    int       m[2][4];
    bit [3:0] mo[2];
    int       checks = 0, passed = 0;

    // Reference: plain integer arithmetic on the bank contents.
    function automatic void mupd(int k, int step, bit sat);
        int v;
        if (Rst) begin
            for (int i = 0; i < 4; i++) m[k][i] = 0;
            mo[k] = 0;
            return;
        end
        if (ClrOvf) mo[k] = 0;
        if (INC != DEC && !(WEN && WSel == ISel)) begin
            v = INC ? m[k][ISel] + step : m[k][ISel] - step;
            if (v < 0 || v > 255) begin
                mo[k][ISel] = 1;
                v = sat ? (INC ? 255 : 0) : (v & 255);
            end
            m[k][ISel] = v;
        end
        if (WEN) begin
            m[k][WSel] = BusOut;
            mo[k][WSel] = 0;
        end
    endfunction

    task automatic cyc(input bit rst, wen, input int ws, bus, input bit inc, dec,
                       input int is, rs, input bit clr, input int csel = 0,
                       input int cd = 0, co = 0, input string nm = "");
        exp_t e;
        @(negedge Clk);
        Rst = rst; WEN = wen; WSel = 2'(ws); BusOut = 8'(bus); INC = inc; DEC = dec;
        ISel = 2'(is); RSel = 2'(rs); ClrOvf = clr;
        mupd(0, 1, 0);
        mupd(1, 4, 1);
        e.dw = 8'(m[0][rs]); e.ow = mo[0];
        e.ds = 8'(m[1][rs]); e.os = mo[1];
        e.csel = csel; e.cd = 8'(cd); e.co = 4'(co); e.name = nm;
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [7:0] act, exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("model dout_w", dout_w, e.dw);
                chk("model ovf_w", {4'b0, ovf_w}, {4'b0, e.ow});
                chk("model dout_s", dout_s, e.ds);
                chk("model ovf_s", {4'b0, ovf_s}, {4'b0, e.os});
                if (e.csel == 1) begin
                    chk({e.name, " dout_w"}, dout_w, e.cd);
                    chk({e.name, " ovf_w"}, {4'b0, ovf_w}, {4'b0, e.co});
                end
                if (e.csel == 2) begin
                    chk({e.name, " dout_s"}, dout_s, e.cd);
                    chk({e.name, " ovf_s"}, {4'b0, ovf_s}, {4'b0, e.co});
                end
            end
        end
    end

    initial begin
        // rst wen ws bus inc dec is rs clr csel cd co name
        cyc(1, 0, 0, 0,    0, 0, 0, 0, 0, 1, 0,    0, "reset1");
        cyc(1, 0, 0, 0,    0, 0, 0, 0, 0, 1, 0,    0, "reset2");
        cyc(0, 1, 2, 'hAA, 0, 0, 0, 2, 0, 1, 'hAA, 0, "write2");
        cyc(0, 0, 0, 0,    0, 0, 0, 0, 0, 1, 0,    0, "read0");
        cyc(0, 0, 0, 0,    0, 0, 0, 1, 0, 1, 0,    0, "read1");
        cyc(0, 0, 0, 0,    0, 0, 0, 3, 0, 1, 0,    0, "read3");
        cyc(0, 1, 1, 'hFE, 0, 0, 0, 1, 0, 1, 'hFE, 0, "write1");
        cyc(0, 0, 0, 0,    1, 0, 1, 1, 0, 1, 'hFF, 0, "wrap_ff");
        cyc(0, 0, 0, 0,    1, 0, 1, 1, 0, 1, 'h00, 2, "wrap_00");
        cyc(0, 0, 0, 0,    1, 0, 1, 1, 0, 1, 'h01, 2, "wrap_01");
        cyc(0, 0, 0, 0,    0, 0, 0, 1, 1, 1, 'h01, 0, "clr_ovf");
        cyc(0, 1, 0, 3,    0, 0, 0, 0, 0, 2, 'h03, 0, "sat_wr0");
        cyc(0, 0, 0, 0,    0, 1, 0, 0, 0, 2, 'h00, 1, "sat_dec");
        cyc(0, 1, 3, 'hFD, 0, 0, 0, 3, 0, 2, 'hFD, 1, "sat_wr3");
        cyc(0, 0, 0, 0,    1, 0, 3, 3, 0, 2, 'hFF, 9, "sat_inc");
        cyc(0, 0, 0, 0,    1, 0, 3, 3, 0, 2, 'hFF, 9, "sat_hold");
        cyc(0, 1, 1, 'hFF, 0, 0, 0, 1, 0, 1, 'hFF, 0, "pre_coll");
        cyc(0, 0, 0, 0,    1, 0, 1, 1, 0, 1, 'h00, 2, "set_ovf1");
        cyc(0, 1, 1, 'h10, 1, 0, 1, 1, 0, 1, 'h10, 0, "coll_same");
        cyc(0, 1, 0, 'h33, 1, 0, 1, 1, 0, 1, 'h11, 0, "coll_diff1");
        cyc(0, 0, 0, 0,    0, 0, 0, 0, 0, 1, 'h33, 0, "coll_diff0");
        cyc(0, 0, 0, 0,    1, 1, 1, 1, 0, 1, 'h11, 0, "inc_dec");
        cyc(0, 1, 1, 'hFF, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0,    1, 0, 1, 1, 0);
        cyc(0, 1, 2, 'hFF, 0, 0, 0, 2, 0);
        for (int i = 0; i < 86; i++) cyc(0, 0, 0, 0, 1, 0, 2, 2, 0);
        cyc(0, 0, 0, 0,    0, 0, 0, 2, 0, 1, 'h55, 6, "pre_rst");
        cyc(1, 1, 2, 'hAA, 1, 0, 2, 2, 0, 1, 0,    0, "rst_mid");
        cyc(0, 0, 0, 0,    0, 0, 0, 1, 0, 1, 0,    0, "post_rst");
        for (int i = 0; i < 200; i++)
            cyc(0, 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
        repeat (3) @(negedge Clk);
        if (q.size() != 0) begin
            checks++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
